// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed N-digit 7-segment display driver. A refresh prescaler
// (pcnt) divides each digit slot into TICK_DIV clocks. The digit index (idx)
// walks 0..DIGITS-1, one step per slot. The packed input value is
// snapshotted once per frame so the display never tears. The first GUARD
// clocks of every slot keep all anodes off, which suppresses ghosting while
// the segment lines settle.
//
// Parameters:
//   DIGITS          digit positions, 1..8
//   TICK_DIV        clocks per digit slot, >= 2
//   GUARD           dark clocks at the start of each slot, < TICK_DIV
//   SEG_ACTIVE_LOW  1 inverts seg/dp at the pins
//   AN_ACTIVE_LOW   1 inverts an at the pins
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   value       packed nibbles, value[3:0] = digit 0 (rightmost, an[0])
//   dp_in       per-digit decimal point request
//   hex_mode    1: nibbles 10..15 shown as A,b,C,d,E,F; 0: blanked (live)
//   blank_in    forces all anodes inactive, scanning continues (live)
//   seg         segment pattern, seg[6]=a .. seg[0]=g (registered)
//   dp          decimal point (registered)
//   an          one-hot digit enable (registered)
//   frame_done  one-clock pulse after the last digit slot ends (registered)
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 is always shown; dp and an are unaffected).
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_mode,
  input  logic                  blank_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_POL   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_POL    = {DIGITS{AN_ACTIVE_LOW}};

  // Scan state
  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap_value;
  logic [DIGITS-1:0]   snap_dp;

  logic slot_tick;
  logic frame_start;
  logic frame_end;

  assign slot_tick   = (pcnt == PCNT_LAST);
  assign frame_start = (pcnt == '0) && (idx == '0);
  assign frame_end   = slot_tick && (idx == IDX_LAST);

  // The snapshot is loaded on the frame-start edge, but that same edge also
  // registers digit 0's outputs. Bypassing the live input here makes digit 0
  // show the data being captured rather than the previous frame's data.
  logic [4*DIGITS-1:0] cur_value;
  logic [DIGITS-1:0]   cur_dp;

  assign cur_value = frame_start ? value : snap_value;
  assign cur_dp    = frame_start ? dp_in : snap_dp;

  // Logical (active-high) pattern for one nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h7E;
      4'h1: pat = 7'h30;
      4'h2: pat = 7'h6D;
      4'h3: pat = 7'h79;
      4'h4: pat = 7'h33;
      4'h5: pat = 7'h5B;
      4'h6: pat = 7'h5F;
      4'h7: pat = 7'h70;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h7B;
      4'hA: pat = hex ? 7'h77 : 7'h00;
      4'hB: pat = hex ? 7'h1F : 7'h00;
      4'hC: pat = hex ? 7'h4E : 7'h00;
      4'hD: pat = hex ? 7'h3D : 7'h00;
      4'hE: pat = hex ? 7'h4F : 7'h00;
      default: pat = hex ? 7'h47 : 7'h00;
    endcase
    return pat;
  endfunction

  // Current digit selection and logical output patterns
  logic [3:0]        nib_sel;
  logic              dp_sel;
  logic              lz_blank;
  logic              guard_ok;
  logic [6:0]        seg_logic;
  logic [DIGITS-1:0] an_logic;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib_sel = cur_value[4*k +: 4];
        dp_sel  = cur_dp[k];
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit k > 0 is blanked while every digit
  // from k upward is zero. Digit 0 is never considered.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (cur_value[4*k +: 4] == 4'h0);
      if ((idx == IW'(k)) && zero_run) begin
        lz_blank = 1'b1;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  // With GUARD = 0 there is no dark window; keep the compare out of the
  // netlist rather than comparing an unsigned counter against zero.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (pcnt >= PW'(GUARD));
    end
  endgenerate

  assign seg_logic = lz_blank ? 7'h00 : decode(nib_sel, hex_mode);
  assign an_logic  = (guard_ok && !blank_in) ? (DIGITS'(1) << idx) : '0;

  // Prescaler, digit index and frame snapshot
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
    end else begin
      if (frame_start) begin
        snap_value <= value;
        snap_dp    <= dp_in;
      end
      if (slot_tick) begin
        pcnt <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Registered pin stage; polarity applied after all logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_POL;
      dp         <= SEG_ACTIVE_LOW;
      an         <= AN_POL;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_logic ^ SEG_POL;
      dp         <= dp_sel ^ SEG_ACTIVE_LOW;
      an         <= an_logic ^ AN_POL;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with DIGITS=4, TICK_DIV=4, GUARD=1,
// active-low anodes and active-high segments. Expected segment codes are
// written out by hand per frame. Outputs are sampled 1 ns after each rising
// edge, and inputs are changed at that same point.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int GUARD    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        hex_mode;
  logic        blank_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_vec  = 0;
  int n_miss = 0;

  seg7_scan_driver #(
    .DIGITS         (DIGITS),
    .TICK_DIV       (TICK_DIV),
    .GUARD          (GUARD),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .hex_mode   (hex_mode),
    .blank_in   (blank_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge; leave the bench 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one full frame starting at the frame-start edge. segs holds the
  // expected pattern of digit k at [7k +: 7]. If do_mid is set, value is
  // switched to mid_value at the start of digit 2's slot.
  task automatic check_frame(input string tag, input logic [27:0] segs,
                             input logic [3:0] dpm, input bit blank,
                             input bit do_mid, input logic [15:0] mid_value);
    for (int i = 0; i < DIGITS * TICK_DIV; i++) begin
      int slot;
      int pos;
      logic [3:0] exp_an;
      slot = i / TICK_DIV;
      pos  = i % TICK_DIV;
      tick();
      exp_an = (pos < GUARD || blank) ? 4'hF : ~(4'b0001 << slot);
      check($sformatf("%s an s%0d p%0d", tag, slot, pos), 32'(an), 32'(exp_an));
      check($sformatf("%s seg s%0d p%0d", tag, slot, pos), 32'(seg), 32'(segs[7*slot +: 7]));
      check($sformatf("%s dp s%0d p%0d", tag, slot, pos), 32'(dp), 32'(dpm[slot]));
      check($sformatf("%s fd s%0d p%0d", tag, slot, pos), 32'(frame_done),
            32'(i == DIGITS * TICK_DIV - 1));
      if (do_mid && i == 2 * TICK_DIV) value = mid_value;
    end
  endtask

  // Expected segment packs, digit 3 .. digit 0
  localparam logic [27:0] SEGS_1234 = {7'h30, 7'h6D, 7'h79, 7'h33};
  localparam logic [27:0] SEGS_9999 = {7'h7B, 7'h7B, 7'h7B, 7'h7B};
  localparam logic [27:0] SEGS_ABCD = {7'h77, 7'h1F, 7'h4E, 7'h3D};
  localparam logic [27:0] SEGS_NONE = 28'h0;

  initial begin
    rst      = 1'b1;
    value    = 16'h1234;
    dp_in    = 4'b0000;
    hex_mode = 1'b0;
    blank_in = 1'b0;

    // Reset state at the pins
    repeat (3) tick();
    check("rst an", 32'(an), 32'hF);
    check("rst seg", 32'(seg), 32'h00);
    check("rst dp", 32'(dp), 32'h0);
    check("rst fd", 32'(frame_done), 32'h0);

    // Scan order, two frames so frame_done is seen repeating every 16 clocks
    rst = 1'b0;
    check_frame("scan0", SEGS_1234, 4'b0000, 1'b0, 1'b0, 16'h0);
    check_frame("scan1", SEGS_1234, 4'b0000, 1'b0, 1'b0, 16'h0);

    // Mid-frame change stays invisible until the next frame
    check_frame("snap_old", SEGS_1234, 4'b0000, 1'b0, 1'b1, 16'h9999);
    check_frame("snap_new", SEGS_9999, 4'b0000, 1'b0, 1'b0, 16'h0);

    // Hex decode on and off
    value    = 16'hABCD;
    hex_mode = 1'b1;
    check_frame("hex1", SEGS_ABCD, 4'b0000, 1'b0, 1'b0, 16'h0);
    hex_mode = 1'b0;
    check_frame("hex0", SEGS_NONE, 4'b0000, 1'b0, 1'b0, 16'h0);

    // Decimal point on digit 2 only
    value = 16'h1234;
    dp_in = 4'b0100;
    check_frame("dp", SEGS_1234, 4'b0100, 1'b0, 1'b0, 16'h0);

    // Blanking: anodes dark, frame_done still pulses
    dp_in    = 4'b0000;
    blank_in = 1'b1;
    check_frame("blank", SEGS_1234, 4'b0000, 1'b1, 1'b0, 16'h0);
    blank_in = 1'b0;

    // Reset in digit 2's slot for one clock
    repeat (2 * TICK_DIV + 1) tick();
    rst = 1'b1;
    tick();
    check("mrst an", 32'(an), 32'hF);
    check("mrst seg", 32'(seg), 32'h00);
    check("mrst fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    check_frame("after_rst", SEGS_1234, 4'b0000, 1'b0, 1'b0, 16'h0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    value = 16'h0050;
    check_frame("lz0050", {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'b0000, 1'b0, 1'b0, 16'h0);
    value = 16'h0000;
    check_frame("lz0000", {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000, 1'b0, 1'b0, 16'h0);
`else
    value = 16'h0050;
    check_frame("nolz0050", {7'h7E, 7'h7E, 7'h5B, 7'h7E}, 4'b0000, 1'b0, 1'b0, 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
